// File: rtl/bp_pkg.sv
// Shared constants and counter helpers for the branch predictor.
package bp_pkg;

  localparam int unsigned MODE_STATIC  = 0;
  localparam int unsigned MODE_DYNAMIC = 1;

  // Weakly-not-taken starting value for a counter of the given width.
  function automatic logic [3:0] ctrInit(input int unsigned bits);
    return 4'((1 << (bits - 1)) - 1);
  endfunction

  function automatic logic [3:0] ctrMax(input int unsigned bits);
    return 4'((1 << bits) - 1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter step: produces the next value of one counter.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic                inc,
  input  logic                dec,
  input  logic [CTR_BITS-1:0] value,
  output logic [CTR_BITS-1:0] result
);

  localparam logic [CTR_BITS-1:0] MAXV = CTR_BITS'(ctrMax(CTR_BITS));

  always_comb begin
    result = value;
    if (inc && value != MAXV) begin
      result = value + CTR_BITS'(1);
    end else if (dec && value != '0) begin
      result = value - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare direction predictor with a direct-mapped BTB and
// non-speculative update from the resolve stage.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned HIST_BITS = 0,
  parameter int unsigned MODE      = 1,
  parameter int unsigned XLEN      = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [XLEN-1:0]             pred_pc,
  output logic                        pred_taken,
  output logic [XLEN-1:0]             pred_target,
  output logic [$clog2(ENTRIES)-1:0]  pred_idx,
  input  logic                        upd_valid,
  input  logic [XLEN-1:0]             upd_pc,
  input  logic [$clog2(ENTRIES)-1:0]  upd_idx,
  input  logic                        upd_taken,
  input  logic [XLEN-1:0]             upd_target,
  input  logic                        upd_pred_taken,
  input  logic [XLEN-1:0]             upd_pred_target,
  output logic                        mispredict,
  output logic [XLEN-1:0]             redirect_pc,
  output logic [31:0]                 br_count,
  output logic [31:0]                 mp_count
);

  localparam int unsigned IDXW = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - IDXW - 2;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctrInit(CTR_BITS));

  logic                validMem  [ENTRIES];
  logic [TAGW-1:0]     tagMem    [ENTRIES];
  logic [XLEN-1:0]     targetMem [ENTRIES];
  logic [CTR_BITS-1:0] ctrMem    [ENTRIES];

  logic [IDXW-1:0]     histMix;
  logic [IDXW-1:0]     lookupIdx;
  logic [TAGW-1:0]     predTag;
  logic                hit;
  logic [CTR_BITS-1:0] ctrNext;

  generate
    if (HIST_BITS > 0) begin : g_ghr
      logic [HIST_BITS-1:0] ghr;
      always_ff @(posedge clk) begin
        if (reset) begin
          ghr <= '0;
        end else if (upd_valid) begin
          ghr <= HIST_BITS'({ghr, upd_taken});
        end
      end
      assign histMix = IDXW'(ghr);
    end else begin : g_noGhr
      assign histMix = '0;
    end
  endgenerate

  assign lookupIdx   = pred_pc[IDXW+1:2] ^ histMix;
  assign predTag     = pred_pc[XLEN-1:IDXW+2];
  assign pred_idx    = lookupIdx;
  assign hit         = validMem[lookupIdx] && (tagMem[lookupIdx] == predTag);
  assign pred_taken  = (MODE == MODE_DYNAMIC) && hit && ctrMem[lookupIdx][CTR_BITS-1];
  assign pred_target = pred_taken ? targetMem[lookupIdx] : pred_pc + XLEN'(4);

  assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  // One shared counter step serves the single update port.
  bp_sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
    .inc    (upd_taken),
    .dec    (!upd_taken),
    .value  (ctrMem[upd_idx]),
    .result (ctrNext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        validMem[i] <= 1'b0;
        ctrMem[i]   <= CTR_INIT;
      end
    end else if (upd_valid) begin
      ctrMem[upd_idx] <= ctrNext;
      if (upd_taken) begin
        validMem[upd_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && upd_valid && upd_taken) begin
      tagMem[upd_idx]    <= upd_pc[XLEN-1:IDXW+2];
      targetMem[upd_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_count <= '0;
      mp_count <= '0;
    end else begin
      if (upd_valid && br_count != '1) begin
        br_count <= br_count + 32'd1;
      end
      if (mispredict && mp_count != '1) begin
        mp_count <= mp_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench: bimodal instance (0) and gshare instance (1) against a table-level model.
module tb_branch_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset          [2];
  logic [63:0] predPc         [2];
  logic        predTaken      [2];
  logic [63:0] predTarget     [2];
  logic [5:0]  predIdx        [2];
  logic        updValid       [2];
  logic [63:0] updPc          [2];
  logic [5:0]  updIdx         [2];
  logic        updTaken       [2];
  logic [63:0] updTarget      [2];
  logic        updPredTaken   [2];
  logic [63:0] updPredTarget  [2];
  logic        mispredict     [2];
  logic [63:0] redirectPc     [2];
  logic [31:0] brCount        [2];
  logic [31:0] mpCount        [2];

  branch_predictor #(.ENTRIES(64), .CTR_BITS(2), .HIST_BITS(0), .MODE(1), .XLEN(64)) dut (
    .clk(clk), .reset(reset[0]), .pred_pc(predPc[0]), .pred_taken(predTaken[0]),
    .pred_target(predTarget[0]), .pred_idx(predIdx[0]), .upd_valid(updValid[0]),
    .upd_pc(updPc[0]), .upd_idx(updIdx[0]), .upd_taken(updTaken[0]),
    .upd_target(updTarget[0]), .upd_pred_taken(updPredTaken[0]),
    .upd_pred_target(updPredTarget[0]), .mispredict(mispredict[0]),
    .redirect_pc(redirectPc[0]), .br_count(brCount[0]), .mp_count(mpCount[0])
  );

  branch_predictor #(.ENTRIES(64), .CTR_BITS(2), .HIST_BITS(4), .MODE(1), .XLEN(64)) dutG (
    .clk(clk), .reset(reset[1]), .pred_pc(predPc[1]), .pred_taken(predTaken[1]),
    .pred_target(predTarget[1]), .pred_idx(predIdx[1]), .upd_valid(updValid[1]),
    .upd_pc(updPc[1]), .upd_idx(updIdx[1]), .upd_taken(updTaken[1]),
    .upd_target(updTarget[1]), .upd_pred_taken(updPredTaken[1]),
    .upd_pred_target(updPredTarget[1]), .mispredict(mispredict[1]),
    .redirect_pc(redirectPc[1]), .br_count(brCount[1]), .mp_count(mpCount[1])
  );

  int passCnt = 0;
  int totalCnt = 0;

  // Reference model: per-instance arrays of entries plus history as an integer.
  bit              mValid  [2][64];
  longint unsigned mTag    [2][64];
  logic [63:0]     mTarget [2][64];
  int              mCtr    [2][64];
  int              mGhr    [2];
  int              histMask[2];
  longint unsigned mBr     [2];
  longint unsigned mMp     [2];

  function automatic int mIdx(int i, logic [63:0] pc);
    return int'((pc >> 2) & 64'd63) ^ mGhr[i];
  endfunction

  function automatic bit mTaken(int i, logic [63:0] pc);
    int k = mIdx(i, pc);
    return mValid[i][k] && (mTag[i][k] == longint'(pc >> 8)) && (mCtr[i][k] >= 2);
  endfunction

  function automatic logic [63:0] mTgt(int i, logic [63:0] pc);
    return mTaken(i, pc) ? mTarget[i][mIdx(i, pc)] : pc + 64'd4;
  endfunction

  function automatic bit mMisp(int i);
    return updValid[i] && ((updTaken[i] != updPredTaken[i]) ||
                           (updTaken[i] && (updTarget[i] != updPredTarget[i])));
  endfunction

  task automatic mReset(int i);
    for (int k = 0; k < 64; k++) begin
      mValid[i][k] = 1'b0;
      mCtr[i][k]   = 1;
    end
    mGhr[i] = 0;
    mBr[i]  = 0;
    mMp[i]  = 0;
  endtask

  task automatic mUpdate(int i);
    int k = int'(updIdx[i]);
    if (mMisp(i) && mMp[i] < 64'hFFFF_FFFF) mMp[i]++;
    if (mBr[i] < 64'hFFFF_FFFF) mBr[i]++;
    if (updTaken[i]) begin
      if (mCtr[i][k] < 3) mCtr[i][k]++;
      mValid[i][k]  = 1'b1;
      mTag[i][k]    = updPc[i] >> 8;
      mTarget[i][k] = updTarget[i];
    end else if (mCtr[i][k] > 0) begin
      mCtr[i][k]--;
    end
    mGhr[i] = ((mGhr[i] << 1) | int'(updTaken[i])) & histMask[i];
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset[i]) mReset(i);
      else if (updValid[i]) mUpdate(i);
    end
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b0;
      updValid[i] = 1'b0;
    end
  endtask

  task automatic drive(int i, logic [63:0] pc, logic tk, logic [63:0] tgt, logic ptk, logic [63:0] ptgt);
    updValid[i] = 1'b1;
    updPc[i] = pc;
    updIdx[i] = 6'(mIdx(i, pc));
    updTaken[i] = tk;
    updTarget[i] = tgt;
    updPredTaken[i] = ptk;
    updPredTarget[i] = ptgt;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1;
      predPc[i] = 64'h100;
      drive(i, 64'h100, 1'b1, 64'h80, 1'b0, 64'h104);
    end
    tick();
    tick();
    idle();
    #2;
    for (int i = 0; i < 2; i++) begin
      totalCnt++;
      if (predTaken[i] !== 1'b0 || predTarget[i] !== 64'h104 || predIdx[i] !== 6'd0)
        $display("FAIL reset_pred inst%0d: got taken=%b tgt=%h idx=%0d want 0/104/0", i, predTaken[i], predTarget[i], predIdx[i]);
      else passCnt++;
      totalCnt++;
      if (brCount[i] !== 32'd0 || mpCount[i] !== 32'd0)
        $display("FAIL reset_counts inst%0d: got br=%0d mp=%0d want 0/0", i, brCount[i], mpCount[i]);
      else passCnt++;
    end
    tick();
  endtask

  task automatic test_train();
    for (int n = 0; n < 2; n++) begin
      drive(0, 64'h100, 1'b1, 64'h80, 1'b0, 64'h104);
      tick();
    end
    idle();
    predPc[0] = 64'h100;
    #2;
    totalCnt++;
    if (predTaken[0] !== 1'b1 || predTarget[0] !== 64'h80)
      $display("FAIL train got taken=%b tgt=%h want 1/80", predTaken[0], predTarget[0]);
    else passCnt++;
    tick();
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 5; n++) begin
      drive(0, 64'h100, 1'b1, 64'h80, 1'b1, 64'h80);
      tick();
    end
    drive(0, 64'h100, 1'b0, 64'h80, 1'b1, 64'h80);
    tick();
    idle();
    #2;
    totalCnt++;
    if (predTaken[0] !== 1'b1 || predTarget[0] !== 64'h80)
      $display("FAIL saturate got taken=%b tgt=%h want 1/80", predTaken[0], predTarget[0]);
    else passCnt++;
    tick();
  endtask

  task automatic test_mispredict();
    drive(0, 64'h100, 1'b1, 64'h80, 1'b0, 64'h104);
    #2;
    totalCnt++;
    if (mispredict[0] !== 1'b1 || redirectPc[0] !== 64'h80)
      $display("FAIL misp_taken got mp=%b redir=%h want 1/80", mispredict[0], redirectPc[0]);
    else passCnt++;
    tick();
    totalCnt++;
    if (mpCount[0] !== 32'(mMp[0]) || brCount[0] !== 32'(mBr[0]))
      $display("FAIL misp_count got mp=%0d br=%0d want %0d/%0d", mpCount[0], brCount[0], mMp[0], mBr[0]);
    else passCnt++;
    drive(0, 64'h100, 1'b0, 64'h80, 1'b1, 64'h80);
    #2;
    totalCnt++;
    if (mispredict[0] !== 1'b1 || redirectPc[0] !== 64'h104)
      $display("FAIL misp_nottaken got mp=%b redir=%h want 1/104", mispredict[0], redirectPc[0]);
    else passCnt++;
    tick();
    idle();
  endtask

  task automatic test_alias_collision();
    predPc[0] = 64'h200;
    #2;
    totalCnt++;
    if (predIdx[0] !== 6'd0 || predTaken[0] !== 1'b0 || predTarget[0] !== 64'h204)
      $display("FAIL alias got idx=%0d taken=%b tgt=%h want 0/0/204", predIdx[0], predTaken[0], predTarget[0]);
    else passCnt++;
    predPc[0] = 64'h304;
    drive(0, 64'h304, 1'b1, 64'h500, 1'b0, 64'h308);
    #2;
    totalCnt++;
    if (predTaken[0] !== 1'b0 || predTarget[0] !== 64'h308)
      $display("FAIL collision_old got taken=%b tgt=%h want 0/308", predTaken[0], predTarget[0]);
    else passCnt++;
    tick();
    idle();
    #2;
    totalCnt++;
    if (predTaken[0] !== 1'b1 || predTarget[0] !== 64'h500)
      $display("FAIL collision_new got taken=%b tgt=%h want 1/500", predTaken[0], predTarget[0]);
    else passCnt++;
    tick();
  endtask

  task automatic test_gshare();
    predPc[1] = 64'h100;
    #2;
    totalCnt++;
    if (predIdx[1] !== 6'd0)
      $display("FAIL gshare_idx0 got %0d want 0", predIdx[1]);
    else passCnt++;
    drive(1, 64'h100, 1'b1, 64'h80, 1'b0, 64'h104);
    tick();
    idle();
    #2;
    totalCnt++;
    if (predIdx[1] !== 6'd1 || predTaken[1] !== 1'b0)
      $display("FAIL gshare_idx1 got idx=%0d taken=%b want 1/0", predIdx[1], predTaken[1]);
    else passCnt++;
    for (int n = 0; n < 4; n++) begin
      drive(1, 64'h180, 1'b0, 64'h0, 1'b0, 64'h184);
      tick();
    end
    idle();
    #2;
    totalCnt++;
    if (predIdx[1] !== 6'd0 || predTaken[1] !== 1'b1 || predTarget[1] !== 64'h80)
      $display("FAIL gshare_wrap got idx=%0d taken=%b tgt=%h want 0/1/80", predIdx[1], predTaken[1], predTarget[1]);
    else passCnt++;
    tick();
  endtask

  task automatic test_random();
    logic [63:0] pcs [8];
    logic [63:0] tgts [4];
    pcs = '{64'h100, 64'h104, 64'h200, 64'h204, 64'h1100, 64'h3fc, 64'h80, 64'hFFFF_FFFF_FFFF_FFFC};
    tgts = '{64'h80, 64'h1000, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0};
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        reset[i] = ($urandom_range(0, 63) == 0);
        predPc[i] = pcs[$urandom_range(0, 7)];
        drive(i, pcs[$urandom_range(0, 7)], 1'($urandom), tgts[$urandom_range(0, 3)], 1'b0, 64'h0);
        updValid[i] = ($urandom_range(0, 3) != 0);
        updPredTaken[i] = $urandom_range(0, 1) ? mTaken(i, updPc[i]) : 1'($urandom);
        updPredTarget[i] = $urandom_range(0, 1) ? mTgt(i, updPc[i]) : tgts[$urandom_range(0, 3)];
      end
      #2;
      for (int i = 0; i < 2; i++) begin
        totalCnt++;
        if (predTaken[i] !== mTaken(i, predPc[i]) || predTarget[i] !== mTgt(i, predPc[i]) ||
            predIdx[i] !== 6'(mIdx(i, predPc[i])))
          $display("FAIL rand_pred inst%0d cyc%0d pc=%h: got %b/%h/%0d want %b/%h/%0d", i, c, predPc[i],
                   predTaken[i], predTarget[i], predIdx[i], mTaken(i, predPc[i]), mTgt(i, predPc[i]), mIdx(i, predPc[i]));
        else passCnt++;
        totalCnt++;
        if (mispredict[i] !== mMisp(i) ||
            redirectPc[i] !== (updTaken[i] ? updTarget[i] : updPc[i] + 64'd4))
          $display("FAIL rand_resolve inst%0d cyc%0d: got mp=%b redir=%h want %b/%h", i, c, mispredict[i], redirectPc[i],
                   mMisp(i), updTaken[i] ? updTarget[i] : updPc[i] + 64'd4);
        else passCnt++;
        totalCnt++;
        if (brCount[i] !== 32'(mBr[i]) || mpCount[i] !== 32'(mMp[i]))
          $display("FAIL rand_counts inst%0d cyc%0d: got br=%0d mp=%0d want %0d/%0d", i, c, brCount[i], mpCount[i], mBr[i], mMp[i]);
        else passCnt++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    histMask[0] = 0;
    histMask[1] = 15;
    mReset(0);
    mReset(1);
    idle();
    for (int i = 0; i < 2; i++) begin
      predPc[i] = '0;
      drive(i, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
      updValid[i] = 1'b0;
    end
    #1;
    test_reset();
    test_train();
    test_saturate();
    test_mispredict();
    test_alias_collision();
    test_gshare();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
